// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl
// Two-way set-associative tag controller. Clears the tag RAM after reset,
// then serves one lookup at a time: a hit refreshes the LRU bit, and a miss
// requests the line from memory and writes the victim way on refill.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_addr   lookup request; accepted when req_ready is high
//   req_ready            high only while idle
//   resp_valid           one-cycle result strobe with resp_hit/resp_way
//   init_done            tag clear sweep finished
//   tag_raddr/tag_re     tag RAM read port (1-cycle latency into tag_dout)
//   tag_waddr/tag_we     tag RAM write port, per-way enable, data tag_din
//   tag_refill           write comes from a line refill
//   tag_load_over        line load finished (refill cycle)
//   tag_cache_reset_n    low while the clear sweep is running
//   mem_req/mem_addr     line fetch request, held until mem_ack
//   mem_ack/mem_done     fetch accepted / line fill finished
//
// Tag word: {lru, valid1, tag1, valid0, tag0}; lru names the way to evict next.
//
// state     | meaning
// INIT      | clear sweep, counter runs over every set
// IDLE      | ready for a request, tag read issued on req_valid
// LOOKUP    | tag word available, compare both ways
// MISS_REQ  | line fetch requested, waiting for mem_ack
// MISS_WAIT | waiting for mem_done
// REFILL    | victim tag written, miss response out

module cache_tag_ctrl #(
  parameter int ADDR_WIDTH   = 7,
  parameter int TAG_WIDTH    = 21,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic                     resp_hit,
  output logic                     resp_way,
  output logic                     init_done,
  output logic [ADDR_WIDTH-1:0]    tag_raddr,
  output logic                     tag_re,
  output logic [ADDR_WIDTH-1:0]    tag_waddr,
  output logic [1:0]               tag_we,
  output logic [2*TAG_WIDTH+2:0]   tag_din,
  input  logic [2*TAG_WIDTH+2:0]   tag_dout,
  output logic                     tag_refill,
  output logic                     tag_load_over,
  output logic                     tag_cache_reset_n,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic                     mem_done
);

  localparam int WORD_W = 2*TAG_WIDTH + 3;
  localparam int LRU_B  = WORD_W - 1;
  localparam int V1_B   = WORD_W - 2;
  localparam int T1_LO  = TAG_WIDTH + 1;
  localparam int V0_B   = TAG_WIDTH;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFSET_WIDTH) - 32'd1);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    REFILL
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   init_cnt;
  logic [31:0]             lat_addr;
  logic                    victim;
  logic [WORD_W-1:0]       old_word;

  logic [TAG_WIDTH-1:0]    lat_tag;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic                    hit0;
  logic                    hit1;
  logic                    hit_way;
  logic                    victim_c;
  logic [WORD_W-1:0]       refill_word;

  assign lat_tag = lat_addr[31 -: TAG_WIDTH];
  assign lat_idx = lat_addr[OFFSET_WIDTH +: ADDR_WIDTH];

  // Read is launched straight from the request so the tag word is ready in LOOKUP.
  assign tag_raddr = req_addr[OFFSET_WIDTH +: ADDR_WIDTH];
  assign tag_re    = (state == IDLE) && req_valid;

  assign hit0    = tag_dout[V0_B] && (tag_dout[TAG_WIDTH-1:0] == lat_tag);
  assign hit1    = tag_dout[V1_B] && (tag_dout[T1_LO +: TAG_WIDTH] == lat_tag);
  // A double hit resolves to way 0.
  assign hit_way = ~hit0;

  // Fill an empty way first; only evict by LRU when both ways are valid.
  assign victim_c = !tag_dout[V0_B] ? 1'b0 :
                    !tag_dout[V1_B] ? 1'b1 : tag_dout[LRU_B];

  always_comb begin
    refill_word = old_word;
    if (victim) begin
      refill_word[T1_LO +: TAG_WIDTH] = lat_tag;
      refill_word[V1_B]               = 1'b1;
    end else begin
      refill_word[TAG_WIDTH-1:0]      = lat_tag;
      refill_word[V0_B]               = 1'b1;
    end
    refill_word[LRU_B] = ~victim;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= INIT;
      init_cnt          <= '0;
      init_done         <= 1'b0;
      req_ready         <= 1'b0;
      resp_valid        <= 1'b0;
      resp_hit          <= 1'b0;
      resp_way          <= 1'b0;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      tag_we            <= 2'b00;
      tag_waddr         <= '0;
      tag_din           <= '0;
      tag_refill        <= 1'b0;
      tag_load_over     <= 1'b0;
      tag_cache_reset_n <= 1'b0;
      lat_addr          <= '0;
      victim            <= 1'b0;
      old_word          <= '0;
    end else begin
      // Strobes default low; states below raise them for a single cycle.
      resp_valid    <= 1'b0;
      tag_we        <= 2'b00;
      tag_refill    <= 1'b0;
      tag_load_over <= 1'b0;

      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) begin
            state             <= IDLE;
            init_done         <= 1'b1;
            req_ready         <= 1'b1;
            tag_cache_reset_n <= 1'b1;
          end
        end

        IDLE: begin
          if (req_valid) begin
            lat_addr  <= req_addr;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (hit0 || hit1) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_way   <= hit_way;
            tag_we     <= hit_way ? 2'b10 : 2'b01;
            tag_waddr  <= lat_idx;
            tag_din    <= {~hit_way, tag_dout[LRU_B-1:0]};
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            victim   <= victim_c;
            old_word <= tag_dout;
            mem_req  <= 1'b1;
            mem_addr <= lat_addr & LINE_MASK;
            state    <= MISS_REQ;
          end
        end

        MISS_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= MISS_WAIT;
          end
        end

        MISS_WAIT: begin
          if (mem_done) begin
            tag_refill    <= 1'b1;
            tag_load_over <= 1'b1;
            tag_waddr     <= lat_idx;
            tag_we        <= victim ? 2'b10 : 2'b01;
            tag_din       <= refill_word;
            resp_valid    <= 1'b1;
            resp_hit      <= 1'b0;
            resp_way      <= victim;
            state         <= REFILL;
          end
        end

        REFILL: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/cache_tag_ctrl.md
CACHE_TAG_CTRL -- requirements
Module: cache_tag_ctrl

Interface
REQ-001 The block SHALL have parameters: ADDR_WIDTH, 7, set index width; TAG_WIDTH, 21, tag width; OFFSET_WIDTH, 4, line offset width (TAG_WIDTH+ADDR_WIDTH+OFFSET_WIDTH = 32).
REQ-002 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-003 Ports SHALL be: clk in 1 clock; rst in 1 sync reset; req_valid in 1 lookup request; req_addr in 32 byte address; req_ready out 1 request accepted when high with req_valid; resp_valid out 1 one-cycle result strobe; resp_hit out 1 hit flag; resp_way out 1 way hit or filled; init_done out 1 tag clear complete.
REQ-004 Tag-RAM ports SHALL be: tag_raddr out ADDR_WIDTH; tag_re out 1; tag_waddr out ADDR_WIDTH; tag_we out 2 per-way write enable; tag_din out 45; tag_dout in 45 (1-cycle read latency); tag_refill out 1; tag_load_over out 1; tag_cache_reset_n out 1 (low = clear sweep active).
REQ-005 Memory ports SHALL be: mem_req out 1; mem_addr out 32 line address; mem_ack in 1 request taken; mem_done in 1 line fill finished.
REQ-006 The 45-bit tag word SHALL be {[44] LRU (way to evict next), [43] valid1, [42:22] tag1, [21] valid0, [20:0] tag0}.

Function
REQ-007 Address split SHALL be tag = addr[31:11], index = addr[10:4], offset = addr[3:0].
REQ-008 FSM states SHALL be INIT, IDLE, LOOKUP, MISS_REQ, MISS_WAIT, REFILL.
REQ-009 INIT: tag_cache_reset_n = 0 and a 7-bit counter runs 0..127; after the cycle with count 127, the FSM goes to IDLE and init_done goes high; init_done stays high until rst.
REQ-010 IDLE: req_ready = 1; tag_raddr = index(req_addr) and tag_re = req_valid. On req_valid, the block latches req_addr and goes to LOOKUP.
REQ-011 req_ready SHALL be 0 in every state except IDLE; req_valid outside IDLE is ignored.
REQ-012 LOOKUP: hitN = validN & (tagN == latched tag); hit = hit0 | hit1.
REQ-013 If both ways hit, the block resolves to way 0.
REQ-014 LOOKUP hit: resp_valid = 1, resp_hit = 1, resp_way = hit way; tag_we = one-hot(hit way), tag_waddr = index, tag_refill = 0, tag_din = tag_dout with [44] = ~hit way; next state IDLE. Total latency is 2 cycles from accept.
REQ-015 LOOKUP miss: victim = way0 if valid0 = 0, else way1 if valid1 = 0, else tag_dout[44]. The victim and the old tag word are latched, and the next state is MISS_REQ.
REQ-016 MISS_REQ: mem_req = 1, mem_addr = {tag, index, 4'b0}; both are held stable until mem_ack, then the FSM goes to MISS_WAIT. mem_ack in the first MISS_REQ cycle is legal.
REQ-017 MISS_WAIT: mem_req = 0; the FSM waits for mem_done, then goes to REFILL. mem_done is sampled only in MISS_WAIT.
REQ-018 REFILL, single cycle, write controls: tag_refill = 1, tag_load_over = 1, tag_waddr = index, tag_we = one-hot(victim).
REQ-019 REFILL, single cycle, write data: tag_din = latched old word with the victim tag field = new tag, victim valid = 1, [44] = ~victim.
REQ-020 REFILL, single cycle, response: resp_valid = 1, resp_hit = 0, resp_way = victim; next state IDLE.
REQ-021 Outside REFILL and a LOOKUP hit, tag_we = 2'b00 and tag_refill = 0; tag_load_over = 0 outside REFILL.
REQ-022 resp_valid SHALL be high for exactly one cycle per accepted request.
REQ-023 At most one request SHALL be outstanding at a time.

Reset
REQ-024 On rst, the FSM SHALL enter INIT with counter = 0 and the following output values: init_done = 0, req_ready = 0, resp_valid = 0, resp_hit = 0, resp_way = 0, mem_req = 0, mem_addr = 0, tag_we = 0, tag_refill = 0, tag_load_over = 0, tag_cache_reset_n = 0.
REQ-025 rst in any state, including MISS_REQ, MISS_WAIT and REFILL, SHALL abort the operation, drop mem_req the next cycle, produce no resp_valid, and restart the full 128-cycle sweep.

Verification
REQ-026 Scenario, init sweep: rst 1 cycle -> tag_cache_reset_n low exactly 128 cycles; req_ready = 0 throughout; init_done = 1 on cycle 129.
REQ-027 Scenario, cold miss: req_addr 0x1234_5670 -> mem_addr 0x1234_5670; after mem_ack then mem_done: tag_we = 2'b01, tag_din[20:0] = 0x2468A, [21] = 1, [44] = 1, resp_hit = 0, resp_way = 0.
REQ-028 Scenario, hit after fill: repeat 0x1234_567C -> resp_valid 2 cycles after accept, resp_hit = 1, resp_way = 0, tag_we = 2'b01, tag_din[44] = 1, mem_req never asserted.
REQ-029 Scenario, LRU eviction: fill 0x0000_0010 (way0) then 0x8000_0010 (way1), hit 0x0000_0010, then miss 0x4000_0010 -> victim way 1, tag_din[44] = 0.
REQ-030 Scenario, mem_ack latency: mem_ack same cycle as first mem_req, and separately after a 5-cycle delay -> mem_addr stable until ack, single REFILL each.
REQ-031 Scenario, reset mid-miss: rst during MISS_WAIT -> no resp_valid, mem_req = 0, INIT resweeps 128 cycles, next request to the same address misses.
